pll_lock_mgr: RTL

Sequencer for a Cyclone V PLL instance and the logic it clocks. It runs on the free-running PLL reference clock. It drives the PLL's reset input with a timed pulse and supervises the PLL lock output, retrying on lock timeout. It holds the downstream system reset until lock has stayed stable for a programmable interval, and re-runs the whole sequence on loss of lock or on software request.

---
 rtl/pll_lock_pkg.sv | 22 ++
 rtl/sync_reg.sv | 23 ++
 rtl/pll_lock_mgr.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pll_lock_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_lock_pkg;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  localparam int LOL_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_reg.sv
// Two-flop synchronizer for a single asynchronous level, cleared by rst.
module sync_reg (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_mgr.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for stable lock with retries,
// then releases sys_rst; restarts on loss of lock or on req.
module pll_lock_mgr
  import pll_lock_pkg::*;
#(
  parameter int RST_CYCLES    = 50,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             fail,
  output logic [2:0]       state,
  output logic [1:0]       retries,
  output logic [LOL_W-1:0] lol_cnt
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MX = 2'(MAX_RETRY);

  logic             locked_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retries_q, retries_d;
  logic [LOL_W-1:0] lol_q, lol_d;
  logic             pll_rst_q, sys_rst_q, fail_q;

  sync_reg u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    lol_d     = lol_q;
    if (req && state_q != S_RESET_PLL) begin
      state_d   = S_RESET_PLL;
      retries_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          // Lock seen on the timeout cycle wins over the retry.
          if (locked_s) state_d = S_STABLE;
          else if (cnt_q == TO_LAST) begin
            if (retries_q == RETRY_MX) state_d = S_FAIL;
            else begin
              retries_d = retries_q + 2'd1;
              state_d   = S_RESET_PLL;
            end
          end
        end
        S_STABLE: begin
          if (!locked_s)             state_d = S_WAIT_LOCK;
          else if (cnt_q == ST_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (!locked_s) begin
            state_d   = S_RESET_PLL;
            retries_d = '0;
          end
        end
        S_FAIL:  ;
        default: state_d = S_RESET_PLL;
      endcase
    end
    // Counted even when req wins the same cycle.
    if (state_q == S_RUN && !locked_s && lol_q != '1) lol_d = lol_q + LOL_W'(1);
  end

  // Only timed states count, so cnt cannot wrap while parked in RUN or FAIL.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (state_q == S_RESET_PLL || state_q == S_WAIT_LOCK || state_q == S_STABLE)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retries_q <= '0;
      lol_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      lol_q     <= lol_d;
      pll_rst_q <= (state_d == S_RESET_PLL);
      sys_rst_q <= (state_d != S_RUN);
      fail_q    <= (state_d == S_FAIL);
    end
  end

  assign pll_rst = pll_rst_q;
  assign sys_rst = sys_rst_q;
  assign fail    = fail_q;
  assign state   = state_q;
  assign retries = retries_q;
  assign lol_cnt = lol_q;

endmodule
